// File: rtl/waiter_pkg.sv
// Shared types and codes for the waiter robot mission sequencer.
package waiter_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned DIR_W   = 3;

  localparam logic [STATE_W-1:0] TABLE_STATE = 4'b0100;

  localparam logic [DIR_W-1:0] DIR_STOP = 3'b000;
  localparam logic [DIR_W-1:0] DIR_FWD  = 3'b001;
  localparam logic [DIR_W-1:0] DIR_REV  = 3'b010;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 4'b0001,
    ST_DRIVE   = 4'b0010,
    ST_BLOCKED = 4'b0011,
    ST_TABLE   = TABLE_STATE,
    ST_RETURN  = 4'b0101
  } state_t;

  // Motor command implied by a mission state; keeps direction locked to state.
  function automatic logic [DIR_W-1:0] dir_of(state_t s);
    case (s)
      ST_DRIVE:  return DIR_FWD;
      ST_RETURN: return DIR_REV;
      default:   return DIR_STOP;
    endcase
  endfunction

endpackage

// File: rtl/waiter_mission_sequencer_sustain_detector.sv
// Fires a single-cycle pulse once level has been high for CYCLES consecutive
// cycles; re-arms only after level drops.
module sustain_detector #(
  parameter int unsigned CYCLES = 25_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic level,
  output logic pulse
);

  localparam int unsigned CW = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [CW-1:0] cnt;
  logic          fired;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      fired <= 1'b0;
    end else if (clear || !level) begin
      cnt   <= '0;
      fired <= 1'b0;
    end else if (cnt != LAST) begin
      cnt <= cnt + CW'(1);
    end else begin
      fired <= 1'b1;
    end
  end

  // Pulse in the CYCLES-th consecutive high cycle, suppressed once fired.
  assign pulse = level && !clear && !fired && (cnt == LAST);

endmodule

// File: rtl/waiter_mission_sequencer.sv
// Mission controller: whistle start, drive with obstacle hold, stop at the
// red table marker, serve, then reverse the odometer distance home.
module waiter_mission_sequencer
  import waiter_pkg::*;
#(
  parameter logic [7:0]  TOO_CLOSE      = 8'd20,
  parameter int unsigned WHISTLE_CYCLES = 25_000_000,
  parameter int unsigned RED_FRAMES     = 3,
  parameter int unsigned SERVE_CYCLES   = 500_000_000,
  parameter int unsigned ODO_W          = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [9:0]         mic_freq,
  input  logic [4:0]         threshold_frequency,
  input  logic [7:0]         distance,
  input  logic [16:0]        red_pixels,
  input  logic [16:0]        threshold_pixels,
  input  logic               frame_sop,
  output logic [DIR_W-1:0]   direction,
  output logic [STATE_W-1:0] state,
  output logic               image_ready,
  output logic               busy
);

  localparam int unsigned RC_W = $clog2(RED_FRAMES + 1);
  localparam int unsigned SV_W = $clog2(SERVE_CYCLES + 1);
  localparam logic [RC_W-1:0] RED_FULL   = RC_W'(RED_FRAMES);
  localparam logic [SV_W-1:0] SERVE_LAST = SV_W'(SERVE_CYCLES - 1);

  state_t             state_q, state_d;
  logic [DIR_W-1:0]   dir_q, dir_d;
  logic               img_q, img_d;
  logic               busy_q, busy_d;
  logic [ODO_W-1:0]   odo_q, odo_d;
  logic [RC_W-1:0]    red_q, red_d;
  logic [SV_W-1:0]    serve_q, serve_d;
  logic               sop_q;

  logic whistle_c, whistle_q, sop_rise, red_hit, red_ok, obst;

  assign whistle_c = mic_freq >= {threshold_frequency, 5'b0_0000};
  assign sop_rise  = frame_sop && !sop_q;
  assign red_hit   = red_pixels > threshold_pixels;
  assign red_ok    = (red_q == RED_FULL);
  assign obst      = distance < TOO_CLOSE;

  sustain_detector #(
    .CYCLES (WHISTLE_CYCLES)
  ) u_whistle (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (!enable),
    .level   (whistle_c),
    .pulse   (whistle_q)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_STOP;
      img_q   <= 1'b0;
      busy_q  <= 1'b0;
      odo_q   <= '0;
      red_q   <= '0;
      serve_q <= '0;
      sop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      img_q   <= img_d;
      busy_q  <= busy_d;
      odo_q   <= odo_d;
      red_q   <= red_d;
      serve_q <= serve_d;
      sop_q   <= frame_sop;
    end
  end

  always_comb begin
    state_d = state_q;
    odo_d   = odo_q;
    red_d   = red_q;
    serve_d = '0;

    // Consecutive red frames, sampled once per camera packet.
    if (sop_rise) begin
      if (!red_hit)             red_d = '0;
      else if (red_q != RED_FULL) red_d = red_q + RC_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (whistle_q) begin
          state_d = ST_DRIVE;
          odo_d   = '0;
          red_d   = '0;
        end
      end
      ST_DRIVE: begin
        if (odo_q != '1) odo_d = odo_q + ODO_W'(1);
        if (red_ok)      state_d = ST_TABLE;
        else if (obst)   state_d = ST_BLOCKED;
      end
      ST_BLOCKED: begin
        if (red_ok)      state_d = ST_TABLE;
        else if (!obst)  state_d = ST_DRIVE;
      end
      ST_TABLE: begin
        serve_d = serve_q + SV_W'(1);
        if ((serve_q == SERVE_LAST) || whistle_q) begin
          state_d = ST_RETURN;
          serve_d = '0;
        end
      end
      ST_RETURN: begin
        if (odo_q == '0) state_d = ST_IDLE;
        else             odo_d   = odo_q - ODO_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    if (!enable) begin
      state_d = ST_IDLE;
      odo_d   = '0;
      red_d   = '0;
      serve_d = '0;
    end

    img_d  = (state_d == ST_TABLE) && (state_q != ST_TABLE);
    dir_d  = dir_of(state_d);
    busy_d = (state_d != ST_IDLE);
  end

  assign state       = state_q;
  assign direction   = dir_q;
  assign image_ready = img_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_waiter_mission_sequencer.sv
// Scoreboard bench: stimulus queues expected state transitions with their
// cycle stamps; a monitor pops and compares whenever the state output moves.
module tb_waiter_mission_sequencer;

  localparam logic [3:0] S_IDLE = 4'b0001, S_DRIVE = 4'b0010, S_BLK = 4'b0011,
                         S_TABLE = 4'b0100, S_RET = 4'b0101;
  localparam logic [2:0] D_STOP = 3'b000, D_FWD = 3'b001, D_REV = 3'b010;

  typedef struct {
    logic [3:0] st;
    logic [2:0] dir;
    logic       busy;
    logic       img;
    int         at;
    string      name;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n, enable, frame_sop;
  logic [9:0]  mic_freq;
  logic [4:0]  threshold_frequency;
  logic [7:0]  distance;
  logic [16:0] red_pixels, threshold_pixels;
  logic [2:0]  direction;
  logic [3:0]  state;
  logic        image_ready, busy;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   img_cnt = 0;
  logic mon_en = 1'b0;

  waiter_mission_sequencer #(
    .TOO_CLOSE      (8'd20),
    .WHISTLE_CYCLES (4),
    .RED_FRAMES     (2),
    .SERVE_CYCLES   (10),
    .ODO_W          (32)
  ) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .enable              (enable),
    .mic_freq            (mic_freq),
    .threshold_frequency (threshold_frequency),
    .distance            (distance),
    .red_pixels          (red_pixels),
    .threshold_pixels    (threshold_pixels),
    .frame_sop           (frame_sop),
    .direction           (direction),
    .state               (state),
    .image_ready         (image_ready),
    .busy                (busy)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [3:0] st, input logic [2:0] dir, input logic bz,
                      input logic img, input int at, input string nm);
    exp_t e;
    e.st = st; e.dir = dir; e.busy = bz; e.img = img; e.at = at; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Monitor: compare each observed state change against the next expectation.
  initial begin
    logic [3:0] prev;
    exp_t e;
    wait (mon_en);
    prev = state;
    forever begin
      @(negedge clk);
      if (image_ready === 1'b1) img_cnt++;
      if (state !== prev) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_transition: got state %b expected no change (cycle %0d)",
                   state, cyc);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_outputs"}, 32'({state, direction, busy, image_ready}),
              32'({e.st, e.dir, e.busy, e.img}));
          if (e.at >= 0) chk({e.name, "_cycle"}, 32'(cyc), 32'(e.at));
        end
        prev = state;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected end of stimulus");
    $fatal(1);
  end

  initial begin
    int c, t0, d, d2, t2, d3, t3, d4, d5;
    reset_n = 1'b1; enable = 1'b1; mic_freq = '0; threshold_frequency = 5'd5;
    distance = 8'd100; red_pixels = '0; threshold_pixels = 17'd1000; frame_sop = 1'b0;
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_state", 32'(state), 32'(S_IDLE));
    chk("rst_dir", 32'(direction), 32'(D_STOP));
    chk("rst_img", 32'(image_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    @(negedge clk);

    // Whistle too short: three cycles only, must stay IDLE.
    c = cyc;
    mic_freq = 10'd200; wait_to(c + 3);
    mic_freq = 10'd100; wait_to(c + 8);

    // Mission 1: whistle held throughout, obstacle hold, table, full serve, return 30.
    t0 = cyc;
    mic_freq = 10'd200;
    push(S_DRIVE, D_FWD, 1'b1, 1'b0, t0 + 4, "m1_drive");
    wait_to(t0 + 23); distance = 8'd10;
    push(S_BLK, D_STOP, 1'b1, 1'b0, t0 + 24, "m1_blocked");
    wait_to(t0 + 38); distance = 8'd50;
    push(S_DRIVE, D_FWD, 1'b1, 1'b0, t0 + 39, "m1_resume");
    d = t0 + 39;
    wait_to(d); red_pixels = 17'd2000;
    wait_to(d + 6); frame_sop = 1'b1;
    wait_to(d + 7); frame_sop = 1'b0;
    wait_to(d + 8); frame_sop = 1'b1;
    wait_to(d + 9); frame_sop = 1'b0;
    push(S_TABLE, D_STOP, 1'b1, 1'b1, d + 10, "m1_table");
    push(S_RET, D_REV, 1'b1, 1'b0, d + 20, "m1_return");
    push(S_IDLE, D_STOP, 1'b0, 1'b0, d + 51, "m1_home");
    wait_to(d + 55); mic_freq = 10'd0;
    wait_to(d + 57);

    // Mission 2: red_ok and obstacle in the same cycle, then early dismiss.
    c = cyc;
    mic_freq = 10'd200;
    d2 = c + 4;
    push(S_DRIVE, D_FWD, 1'b1, 1'b0, d2, "m2_drive");
    wait_to(d2); mic_freq = 10'd0; frame_sop = 1'b1;
    wait_to(d2 + 1); frame_sop = 1'b0;
    wait_to(d2 + 2); frame_sop = 1'b1;
    wait_to(d2 + 3); frame_sop = 1'b0; distance = 8'd10;
    t2 = d2 + 4;
    push(S_TABLE, D_STOP, 1'b1, 1'b1, t2, "m2_priority");
    wait_to(t2); mic_freq = 10'd200;
    push(S_RET, D_REV, 1'b1, 1'b0, t2 + 4, "m2_dismiss");
    push(S_IDLE, D_STOP, 1'b0, 1'b0, t2 + 9, "m2_home");
    wait_to(t2 + 4); mic_freq = 10'd0; distance = 8'd50;
    wait_to(t2 + 12);

    // Mission 3: asynchronous reset in the middle of RETURN.
    c = cyc;
    mic_freq = 10'd200;
    d3 = c + 4;
    push(S_DRIVE, D_FWD, 1'b1, 1'b0, d3, "m3_drive");
    wait_to(d3); mic_freq = 10'd0; frame_sop = 1'b1;
    wait_to(d3 + 1); frame_sop = 1'b0;
    wait_to(d3 + 2); frame_sop = 1'b1;
    wait_to(d3 + 3); frame_sop = 1'b0;
    t3 = d3 + 4;
    push(S_TABLE, D_STOP, 1'b1, 1'b1, t3, "m3_table");
    wait_to(t3); mic_freq = 10'd200;
    push(S_RET, D_REV, 1'b1, 1'b0, t3 + 4, "m3_return");
    wait_to(t3 + 4); mic_freq = 10'd0;
    wait_to(t3 + 5);
    push(S_IDLE, D_STOP, 1'b0, 1'b0, -1, "m3_reset");
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("async_state", 32'(state), 32'(S_IDLE));
    chk("async_dir", 32'(direction), 32'(D_STOP));
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_img", 32'(image_ready), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Mission 4: enable dropped in DRIVE, then a single red frame is not enough.
    c = cyc;
    red_pixels = 17'd2000;
    mic_freq = 10'd200;
    d4 = c + 4;
    push(S_DRIVE, D_FWD, 1'b1, 1'b0, d4, "m4_drive");
    wait_to(d4); mic_freq = 10'd0; frame_sop = 1'b1;
    wait_to(d4 + 1); frame_sop = 1'b0;
    wait_to(d4 + 2); enable = 1'b0;
    push(S_IDLE, D_STOP, 1'b0, 1'b0, d4 + 3, "m4_disable");
    wait_to(d4 + 3); enable = 1'b1;
    wait_to(d4 + 5);
    c = cyc;
    mic_freq = 10'd200;
    d5 = c + 4;
    push(S_DRIVE, D_FWD, 1'b1, 1'b0, d5, "m4_redrive");
    wait_to(d5); mic_freq = 10'd0; frame_sop = 1'b1;
    wait_to(d5 + 1); frame_sop = 1'b0;
    wait_to(d5 + 8); distance = 8'd10;
    push(S_BLK, D_STOP, 1'b1, 1'b0, d5 + 9, "m4_blocked");
    wait_to(d5 + 12); distance = 8'd50;
    push(S_DRIVE, D_FWD, 1'b1, 1'b0, d5 + 13, "m4_resume");
    wait_to(d5 + 15); enable = 1'b0;
    push(S_IDLE, D_STOP, 1'b0, 1'b0, d5 + 16, "m4_stop");
    wait_to(d5 + 18); enable = 1'b1;
    wait_to(d5 + 22);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("img_pulses", 32'(img_cnt), 32'd3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/waiter_mission_sequencer.md
# waiter_mission_sequencer

Top-level mission controller for the waiter robot. It sequences the drive datapath through one delivery: wait for a whistle, drive forward, hold for obstacles, stop at the red table marker, serve, then reverse the same distance home. It replaces the free-running direction logic and the hard-wired table state. It drives the `direction` bus into `speed_fsm` and `drive_motor`. It also drives the `state` and `image_ready` inputs of `image_send_select`.

## Interface
Parameters:
- `TOO_CLOSE`, default 8'd20: obstacle distance threshold, in ultrasonic units.
- `WHISTLE_CYCLES`, default 25_000_000: consecutive whistle cycles needed to qualify a whistle (0.5 s).
- `RED_FRAMES`, default 3: consecutive red-over-threshold frames needed to confirm the table.
- `SERVE_CYCLES`, default 500_000_000: dwell time at the table (10 s).
- `ODO_W`, default 32: odometer width.

Ports:
- `clk` in 1: CLOCK_50.
- `reset_n` in 1: asynchronous, active-low reset.
- `enable` in 1: synchronous run enable. While low, the block is held in IDLE.
- `mic_freq` in 10: FFT pitch.
- `threshold_frequency` in 5: whistle threshold (SW[17:13]).
- `distance` in 8: ultrasonic distance.
- `red_pixels` in 17: red pixel count of the last frame.
- `threshold_pixels` in 17: red pixel threshold.
- `frame_sop` in 1: camera start-of-packet. Level input; it is edge-detected internally.
- `direction` out 3: motor command.
- `state` out 4: mission state code.
- `image_ready` out 1: one-cycle pulse on entering TABLE.
- `busy` out 1: high in any state other than IDLE.

## Operation
- Whistle condition: `mic_freq >= {threshold_frequency, 5'b0}`, with both operands zero-extended to 10 bits.
- Whistle qualification:
  - The whistle condition must be high for WHISTLE_CYCLES consecutive cycles.
  - Qualification produces a single-cycle `whistle_q` pulse.
  - The condition must drop low before the detector can fire again.
- Red frame counting:
  - On each rising edge of `frame_sop`, the block samples `red_pixels > threshold_pixels`.
  - A true sample increments a frame counter; a false sample clears it.
  - The counter saturates at RED_FRAMES.
  - `red_ok` is true when the counter equals RED_FRAMES.
- Obstacle condition: `obst = distance < TOO_CLOSE`.
- Direction codes (package): STOP 3'b000, FWD 3'b001, REV 3'b010.
- States, with their `state` codes:
  - IDLE (4'b0001):
    - `direction` = STOP.
    - `whistle_q` → DRIVE, and the odometer and red counter are cleared.
  - DRIVE (4'b0010):
    - `direction` = FWD, and the odometer increments every cycle, saturating at all-ones.
    - `red_ok` → TABLE. This has priority over `obst`.
    - Otherwise, `obst` → BLOCKED.
  - BLOCKED (4'b0011):
    - `direction` = STOP, and the odometer is frozen.
    - `red_ok` → TABLE.
    - `!obst` → DRIVE.
  - TABLE (4'b0100):
    - `direction` = STOP.
    - `image_ready` pulses on the entry cycle.
    - The serve timer counts from 0. At SERVE_CYCLES-1, or on `whistle_q` (early dismiss), the next state is RETURN.
  - RETURN (4'b0101):
    - `direction` = REV, and the odometer decrements every cycle.
    - When the odometer is 0 → IDLE. This includes an odometer already at 0 on entry: that gives one RETURN cycle, then IDLE.
    - `distance` and `red_ok` are ignored.
- `enable` low:
  - The next state is IDLE.
  - All counters clear and `image_ready` is 0.
  - This overrides every other transition.

## Timing
- All outputs are registered.
- A condition true in cycle N changes `state` and `direction` at edge N+1. `direction` always matches `state` in the same cycle.
- Whistle latency: a condition first true at cycle 0 gives `whistle_q` at cycle WHISTLE_CYCLES-1 and DRIVE at cycle WHISTLE_CYCLES.
- `frame_sop` edge detection adds 1 cycle before the red counter updates.
- RETURN lasts exactly odometer+1 cycles. DRIVE cycles spent entering BLOCKED are counted; BLOCKED cycles are not.
- Reset values (`reset_n` low, async, at any point mid-mission):
  - `state` = IDLE and `direction` = STOP.
  - `image_ready` = 0 and `busy` = 0.
  - All counters and the sop edge register are 0.

## Structure
- `waiter_pkg` holds:
  - the state enum (4-bit, codes as above);
  - the direction codes;
  - `TABLE_STATE` = 4'b0100.
- Sub-module `sustain_detector` (parameter `CYCLES`; ports `clk`, `reset_n`, `clear`, `level`, `pulse`) implements the whistle qualifier.
- The red frame counter and serve timer stay inline.

## Test plan
Bench parameters: WHISTLE_CYCLES=4, RED_FRAMES=2, SERVE_CYCLES=10, TOO_CLOSE=20, threshold_frequency=5 (160), threshold_pixels=1000.
- **Whistle qualify:** `mic_freq`=200 held 3 cycles, then 100 → remains IDLE. Hold 200 for 4 cycles → DRIVE with `direction`=001 one cycle after the 4th. Keep holding → no second pulse.
- **Obstacle hold:** in DRIVE after 20 cycles, `distance`=10 for 15 cycles then 50 → BLOCKED/000 for 15 cycles, then DRIVE. The odometer resumes counting from its frozen value.
- **Table stop and serve:** `red_pixels`=2000 across two `frame_sop` edges → TABLE with `image_ready` high for exactly 1 cycle. RETURN follows after 10 cycles.
- **Return distance:** odometer=30 at TABLE → RETURN/010 for 31 cycles, then IDLE with `busy`=0.
- **Priority and early dismiss:**
  - `red_ok` and `distance`=10 in the same DRIVE cycle → TABLE, not BLOCKED.
  - A qualified whistle at TABLE cycle 3 → RETURN at cycle 4.
- **Reset and enable:**
  - `reset_n` low mid-RETURN → state 0001, direction 000, `busy` 0 asynchronously.
  - `enable` low in DRIVE → IDLE next edge. The red counter is cleared, so a single red frame afterwards does not reach TABLE.
